seg7_scan_driver: RTL

Parametrised multi-digit 7-segment scan driver for the board's common-anode display bank. It holds a double-buffered hex word with per-digit decimal points and enables, and time-multiplexes the digits at a programmable slot rate. Each slot starts with a dead-time (ghosting guard), and the block can optionally suppress leading zeros. It sits between the system registers that produce display values and the top-level `AN`/`CA..CG`/`DP` pins, and it supersedes per-digit nibble-to-hex conversion.

---
 rtl/seg7_scan_driver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a common-anode 7-segment display bank.
// Display data is double-buffered: loads land in a shadow copy and are
// committed to the active copy only at a frame boundary, so a scan never
// shows a mix of old and new digits. Each digit slot opens with a dead-time
// in which every anode is off, which stops the previous digit ghosting.
// All pin-facing outputs are registered and lag the counters by one cycle.

module seg7_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int TICK_DIV   = 100000,
    parameter int DEAD       = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   Val_I,
    input  logic [DIGITS-1:0]     Dp_I,
    input  logic [DIGITS-1:0]     En_I,
    input  logic                  Blank_Zero_I,
    input  logic                  Load_I,
    output logic [6:0]            Seg_O,
    output logic                  Dp_O,
    output logic [DIGITS-1:0]     An_O,
    output logic                  Frame_O
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Polarity mask: every display output is XORed with this before it leaves.
    localparam logic POL = (ACTIVE_LOW != 0);

    // Hex nibble to active-high segment pattern, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h27;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h67;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Scan counters
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;

    // Shadow buffer (written by loads) and pending flag
    logic [4*DIGITS-1:0] shd_val_r;
    logic [DIGITS-1:0]   shd_dp_r;
    logic [DIGITS-1:0]   shd_en_r;
    logic                shd_bz_r;
    logic                pend_r;

    // Active buffer (what the scan displays)
    logic [4*DIGITS-1:0] act_val_r;
    logic [DIGITS-1:0]   act_dp_r;
    logic [DIGITS-1:0]   act_en_r;
    logic                act_bz_r;

    // Registered pin drivers
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic                frame_r;

    // Combinational helpers
    logic                slot_end_s;
    logic                boundary_s;
    logic                in_dead_s;
    logic                lit_s;
    logic                blank_s;
    logic [3:0]          dig_nib_s;
    logic [DIGITS-1:0]   an_s;
    logic [6:0]          seg_s;
    logic                dp_s;

    assign slot_end_s = (cnt_r == CNT_LAST);
    assign boundary_s = slot_end_s && (idx_r == IDX_LAST);

    // With no dead-time the comparison would be constant, so elaborate it away.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead_s = 1'b0;
        end else begin : g_dead
            assign in_dead_s = (cnt_r < CNT_W'(DEAD));
        end
    endgenerate

    // Slot counter and digit index; the index wraps on the frame boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= boundary_s ? '0 : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Shadow capture: any load away from the boundary, last one wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shd_val_r <= '0;
            shd_dp_r  <= '0;
            shd_en_r  <= '0;
            shd_bz_r  <= 1'b0;
        end else if (Load_I && !boundary_s) begin
            shd_val_r <= Val_I;
            shd_dp_r  <= Dp_I;
            shd_en_r  <= En_I;
            shd_bz_r  <= Blank_Zero_I;
        end
    end

    // Active buffer commit at the frame boundary; a load on that very cycle
    // bypasses the shadow and goes straight to the display.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            act_val_r <= '0;
            act_dp_r  <= '0;
            act_en_r  <= '0;
            act_bz_r  <= 1'b0;
            pend_r    <= 1'b0;
        end else if (boundary_s) begin
            pend_r <= 1'b0;
            if (Load_I) begin
                act_val_r <= Val_I;
                act_dp_r  <= Dp_I;
                act_en_r  <= En_I;
                act_bz_r  <= Blank_Zero_I;
            end else if (pend_r) begin
                act_val_r <= shd_val_r;
                act_dp_r  <= shd_dp_r;
                act_en_r  <= shd_en_r;
                act_bz_r  <= shd_bz_r;
            end
        end else if (Load_I) begin
            pend_r <= 1'b1;
        end
    end

    // Current digit nibble and leading-zero test (digit 0 is never blanked).
    always_comb begin
        dig_nib_s = act_val_r[{idx_r, 2'b00} +: 4];
        blank_s   = 1'b0;
        if (act_bz_r && (idx_r != '0)) begin
            blank_s = ((act_val_r >> {idx_r, 2'b00}) == '0);
        end else begin
            blank_s = 1'b0;
        end
    end

    // Active-high anode/segment/dp pattern for the current counter state.
    always_comb begin
        lit_s = !in_dead_s && act_en_r[idx_r];
        an_s  = '0;
        seg_s = 7'h00;
        dp_s  = 1'b0;
        if (lit_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_s[i] = (idx_r == IDX_W'(i));
            end
            seg_s = blank_s ? 7'h00 : hex_seg(dig_nib_s);
            dp_s  = act_dp_r[idx_r];
        end else begin
            an_s  = '0;
            seg_s = 7'h00;
            dp_s  = 1'b0;
        end
    end

    // Output registers with board polarity applied; reset parks everything off.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an_r    <= {DIGITS{POL}};
            seg_r   <= {7{POL}};
            dp_r    <= POL;
            frame_r <= 1'b0;
        end else begin
            an_r    <= an_s ^ {DIGITS{POL}};
            seg_r   <= seg_s ^ {7{POL}};
            dp_r    <= dp_s ^ POL;
            frame_r <= boundary_s;
        end
    end

    assign An_O    = an_r;
    assign Seg_O   = seg_r;
    assign Dp_O    = dp_r;
    assign Frame_O = frame_r;

endmodule
